irrigation_scheduler: RTL and testbench
=======================================

// Module: irrigation_scheduler
// PURPOSE
//  Sequences the shared water tank between two irrigation zones (sprinkler, drip) and the refill pump.
//  Round-robin arbiter plus timed-grant FSM: only one consumer (zone valve or fill pump) is active at a time.
//  Sits above the irrigation state logic; consumes the 4-bit thermometer tank level and zone requests,
//  drives the valve/pump enables and reports its state.
// PARAMETERS
//  IRRIG_CYCLES  8   clock cycles a granted valve stays open per grant (>=1)
//  FILL_TIMEOUT  32  max cycles in REFILL before declaring a fault (>=1)
//  TIMER_W       6   width of the shared down-counter; must hold max(IRRIG_CYCLES,FILL_TIMEOUT)-1
// PORTS
//  clk               in   1  system clock, rising edge
//  initialize        in   1  synchronous active-high reset
//  water_tank_level  in   4  thermometer level: [0]=min, [1]=low, [2]=mid, [3]=full
//  req_sprinkler     in   1  sprinkler zone requests water (level-sensitive)
//  req_drip          in   1  drip zone requests water (level-sensitive)
//  clear_fault       in   1  leave FAULT (sampled only in FAULT)
//  valve_sprinkler   out  1  sprinkler valve open
//  valve_drip        out  1  drip valve open
//  pump_fill         out  1  refill pump on
//  alarm             out  1  high while in FAULT
//  grant_done        out  1  one-cycle pulse when a grant completes its full IRRIG_CYCLES
//  state             out  3  current FSM state encoding
// BEHAVIOUR
//  Single clock; one synchronous active-high reset; all outputs registered (Moore, decoded from state reg).
//  States: IDLE=3'd0, SPRINKLER=3'd1, DRIP=3'd2, REFILL=3'd3, FAULT=3'd4; 5..7 illegal -> IDLE next cycle.
//  Reset: state=IDLE, all outputs 0, timer=0, last_grant=DRIP (so sprinkler wins the first tie).
//  Reset wins over every other event, including mid-grant / mid-refill (valve/pump drop next edge).
//  IDLE:
//   - level[0]==0 -> REFILL.
//   - else arbitrate: one request -> that zone; both -> zone != last_grant (round-robin).
//   - sprinkler additionally needs level[1]==1; if the winner's level requirement fails -> REFILL.
//   - no request -> stay IDLE.
//   - On entry to a zone state: timer loads IRRIG_CYCLES-1; the valve is high for exactly IRRIG_CYCLES cycles,
//     starting the cycle after the IDLE decision (1-cycle decision latency).
//  SPRINKLER / DRIP:
//   - timer decrements each cycle; at timer==0 -> IDLE, last_grant=this zone, grant_done pulses in the
//     first IDLE cycle.
//   - level[0] falls -> REFILL (no grant_done, last_grant unchanged); has priority over request drop
//     and timer expiry in the same cycle.
//   - request deasserts -> IDLE early (no grant_done, last_grant=this zone).
//  REFILL:
//   - pump_fill=1; timer loaded FILL_TIMEOUT-1 on entry, decrements.
//   - level[3]==1 -> IDLE (checked before timeout).
//   - timer==0 with level[3]==0 -> FAULT.
//  FAULT:
//   - all valves/pump 0, alarm=1.
//   - clear_fault=1 -> IDLE; otherwise hold until reset.
//  Requests are ignored outside IDLE except as the early-termination check above.
//  Timer is saturating at 0; no wrap.
// CONFIGURATION
//  SENSOR_CHECK_EN defined:
//   - non-thermometer level (any bit[i]=1 with bit[i-1]=0, e.g. 4'b0101) in any non-FAULT state
//     -> FAULT next cycle (valves/pump off); has highest priority after reset.
//  SENSOR_CHECK_EN undefined:
//   - no validity check; each level bit is used individually as specified above.
// TESTING
//  1. initialize=1 2 cycles, level=4'b1111, both reqs held -> state 1, valve_sprinkler high 8 cycles,
//     grant_done pulse, then state 2, valve_drip high 8 cycles (alternation).
//  2. level=4'b0000, req_drip=1 -> REFILL next cycle, pump_fill=1; level=4'b1111 at cycle 10
//     -> IDLE next edge, then DRIP.
//  3. level held 4'b0001 in REFILL -> FAULT after 32 cycles, alarm=1; clear_fault=1 with level=4'b1111
//     -> IDLE, alarm=0.
//  4. Sprinkler grant at cycle 3 of 8, level drops to 4'b0000 while req also drops -> valve off,
//     REFILL (not IDLE), no grant_done.
//  5. level=4'b0101 in IDLE: with SENSOR_CHECK_EN -> FAULT, alarm=1; without it -> sprinkler grant
//     refused (bit1=0) -> REFILL.
//  6. initialize pulsed mid-REFILL (cycle 5) -> next edge pump_fill=0, state=0, outputs all 0.

Source files
------------

// File: rtl/irrigation_scheduler_if.sv
// Tank-sharing bus between the irrigation scheduler and its surroundings:
// tank level, zone requests and fault clear in, valve/pump/status out.
interface irrigation_scheduler_if;
  logic [3:0] water_tank_level;
  logic       req_sprinkler;
  logic       req_drip;
  logic       clear_fault;
  logic       valve_sprinkler;
  logic       valve_drip;
  logic       pump_fill;
  logic       alarm;
  logic       grant_done;
  logic [2:0] state;

  modport master (
    output water_tank_level, req_sprinkler, req_drip, clear_fault,
    input  valve_sprinkler, valve_drip, pump_fill, alarm, grant_done, state
  );

  modport slave (
    input  water_tank_level, req_sprinkler, req_drip, clear_fault,
    output valve_sprinkler, valve_drip, pump_fill, alarm, grant_done, state
  );
endinterface

// File: rtl/irrigation_scheduler.sv
// Round-robin, timed-grant scheduler giving the shared tank to one consumer at a time.
// Optional macro SENSOR_CHECK_EN: a non-thermometer tank level forces FAULT.
module irrigation_scheduler #(
  parameter int IRRIG_CYCLES = 8,
  parameter int FILL_TIMEOUT = 32,
  parameter int TIMER_W      = 6
) (
  input  logic                   clk,
  input  logic                   initialize,
  irrigation_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPRINKLER = 3'd1,
    ST_DRIP      = 3'd2,
    ST_REFILL    = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic GRANT_SPRINKLER = 1'b0;
  localparam logic GRANT_DRIP      = 1'b1;
  localparam logic [TIMER_W-1:0] IRRIG_LOAD = TIMER_W'(IRRIG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FILL_LOAD  = TIMER_W'(FILL_TIMEOUT - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [TIMER_W-1:0]   timer_r;
  logic [TIMER_W-1:0]   timer_nxt_s;
  logic [TIMER_W-1:0]   timer_dec_s;
  logic                 last_grant_r;
  logic                 last_grant_nxt_s;
  logic                 done_nxt_s;
  logic                 valve_sprinkler_r;
  logic                 valve_drip_r;
  logic                 pump_fill_r;
  logic                 alarm_r;
  logic                 grant_done_r;
  logic                 pick_sprinkler_s;
  logic                 zone_req_s;
  logic                 sensor_fault_s;
  logic                 unused_level_s;
  logic [3:0]           level_s;

`ifdef SENSOR_CHECK_EN
  function automatic logic level_is_thermometer(input logic [3:0] level);
    return (level == 4'b0000) || (level == 4'b0001) || (level == 4'b0011) ||
           (level == 4'b0111) || (level == 4'b1111);
  endfunction

  assign sensor_fault_s = !level_is_thermometer(level_s);
`else
  assign sensor_fault_s = 1'b0;
`endif

  assign level_s          = bus.water_tank_level;
  assign unused_level_s   = level_s[2];
  assign timer_dec_s      = (timer_r == {TIMER_W{1'b0}}) ? timer_r : timer_r - {{(TIMER_W-1){1'b0}}, 1'b1};
  // Sprinkler wins when it is the only requester or when drip was served last.
  assign pick_sprinkler_s = bus.req_sprinkler && (!bus.req_drip || (last_grant_r == GRANT_DRIP));
  assign zone_req_s       = (state_r == ST_SPRINKLER) ? bus.req_sprinkler : bus.req_drip;

  // Next-state, timer and round-robin bookkeeping.
  always_comb begin
    state_nxt_s      = state_r;
    timer_nxt_s      = timer_dec_s;
    last_grant_nxt_s = last_grant_r;
    done_nxt_s       = 1'b0;
    if (sensor_fault_s && (state_r != ST_FAULT)) begin
      state_nxt_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!level_s[0]) begin
            state_nxt_s = ST_REFILL;
            timer_nxt_s = FILL_LOAD;
          end else if (bus.req_sprinkler || bus.req_drip) begin
            if (!pick_sprinkler_s) begin
              state_nxt_s = ST_DRIP;
              timer_nxt_s = IRRIG_LOAD;
            end else if (level_s[1]) begin
              state_nxt_s = ST_SPRINKLER;
              timer_nxt_s = IRRIG_LOAD;
            end else begin
              state_nxt_s = ST_REFILL;
              timer_nxt_s = FILL_LOAD;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SPRINKLER, ST_DRIP: begin
          // Losing the water supply outranks both expiry and request drop.
          if (!level_s[0]) begin
            state_nxt_s = ST_REFILL;
            timer_nxt_s = FILL_LOAD;
          end else if ((timer_r == {TIMER_W{1'b0}}) || !zone_req_s) begin
            state_nxt_s      = ST_IDLE;
            last_grant_nxt_s = (state_r == ST_SPRINKLER) ? GRANT_SPRINKLER : GRANT_DRIP;
            done_nxt_s       = (timer_r == {TIMER_W{1'b0}});
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_REFILL: begin
          if (level_s[3]) begin
            state_nxt_s = ST_IDLE;
          end else if (timer_r == {TIMER_W{1'b0}}) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_REFILL;
          end
        end
        ST_FAULT: begin
          if (bus.clear_fault) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (initialize) begin
      state_r           <= ST_IDLE;
      timer_r           <= {TIMER_W{1'b0}};
      last_grant_r      <= GRANT_DRIP;
      valve_sprinkler_r <= 1'b0;
      valve_drip_r      <= 1'b0;
      pump_fill_r       <= 1'b0;
      alarm_r           <= 1'b0;
      grant_done_r      <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      timer_r           <= timer_nxt_s;
      last_grant_r      <= last_grant_nxt_s;
      valve_sprinkler_r <= (state_nxt_s == ST_SPRINKLER);
      valve_drip_r      <= (state_nxt_s == ST_DRIP);
      pump_fill_r       <= (state_nxt_s == ST_REFILL);
      alarm_r           <= (state_nxt_s == ST_FAULT);
      grant_done_r      <= done_nxt_s;
    end
  end

  assign bus.valve_sprinkler = valve_sprinkler_r;
  assign bus.valve_drip      = valve_drip_r;
  assign bus.pump_fill       = pump_fill_r;
  assign bus.alarm           = alarm_r;
  assign bus.grant_done      = grant_done_r;
  assign bus.state           = state_r;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model of the scheduling rules.
module tb_irrigation_scheduler;
  localparam int IRRIG = 8;
  localparam int FILL  = 32;
  localparam int M_IDLE = 0, M_SPR = 1, M_DRIP = 2, M_REFILL = 3, M_FAULT = 4;

  logic clk = 1'b0;
  logic initialize = 1'b1;
  irrigation_scheduler_if bus();

  irrigation_scheduler #(.IRRIG_CYCLES(IRRIG), .FILL_TIMEOUT(FILL), .TIMER_W(6)) dut (
    .clk(clk), .initialize(initialize), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode in spec encoding, cycles a valve has been open, cycles spent refilling.
  int m_mode = M_IDLE;
  int m_held = 0;
  int m_fill = 0;
  int m_last = M_DRIP;
  int m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_thermo(input logic [3:0] l);
    return (l == 4'b0000) || (l == 4'b0001) || (l == 4'b0011) || (l == 4'b0111) || (l == 4'b1111);
  endfunction

  task automatic model_step();
    logic [3:0] lv;
    bit sensor_bad;
    int winner;
    lv = bus.water_tank_level;
    m_done = 0;
`ifdef SENSOR_CHECK_EN
    sensor_bad = !is_thermo(lv);
`else
    sensor_bad = 1'b0;
`endif
    if (initialize) begin
      m_mode = M_IDLE; m_last = M_DRIP; m_held = 0; m_fill = 0;
    end else if (sensor_bad && m_mode != M_FAULT) begin
      m_mode = M_FAULT;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (!lv[0]) begin
            m_mode = M_REFILL; m_fill = 0;
          end else if (bus.req_sprinkler || bus.req_drip) begin
            if (bus.req_sprinkler && bus.req_drip) winner = (m_last == M_SPR) ? M_DRIP : M_SPR;
            else winner = bus.req_sprinkler ? M_SPR : M_DRIP;
            if (winner == M_SPR && !lv[1]) begin
              m_mode = M_REFILL; m_fill = 0;
            end else begin
              m_mode = winner; m_held = 0;
            end
          end
        end
        M_SPR, M_DRIP: begin
          if (!lv[0]) begin
            m_mode = M_REFILL; m_fill = 0;
          end else begin
            m_held++;
            if (m_held == IRRIG) begin
              m_last = m_mode; m_mode = M_IDLE; m_done = 1;
            end else if (!((m_mode == M_SPR) ? bus.req_sprinkler : bus.req_drip)) begin
              m_last = m_mode; m_mode = M_IDLE;
            end
          end
        end
        M_REFILL: begin
          m_fill++;
          if (lv[3]) m_mode = M_IDLE;
          else if (m_fill == FILL) m_mode = M_FAULT;
        end
        default: begin
          if (bus.clear_fault) m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic compare_model();
    chk("state", bus.state, m_mode);
    chk("valve_sprinkler", bus.valve_sprinkler, m_mode == M_SPR);
    chk("valve_drip", bus.valve_drip, m_mode == M_DRIP);
    chk("pump_fill", bus.pump_fill, m_mode == M_REFILL);
    chk("alarm", bus.alarm, m_mode == M_FAULT);
    chk("grant_done", bus.grant_done, m_done);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    initialize = 1'b1;
    bus.req_sprinkler = 1'b0; bus.req_drip = 1'b0; bus.clear_fault = 1'b0;
    bus.water_tank_level = 4'b1111;
    step(); step();
    initialize = 1'b0;
  endtask

  initial begin
    int sv_cnt, vd_cnt, gd_cnt;
    logic [3:0] thermo_tab [5];
    thermo_tab[0] = 4'b0000; thermo_tab[1] = 4'b0001; thermo_tab[2] = 4'b0011;
    thermo_tab[3] = 4'b0111; thermo_tab[4] = 4'b1111;

    // Reset and round-robin alternation with both zones requesting.
    do_reset();
    chk("reset_state", bus.state, 3'd0);
    chk("reset_outputs", {bus.valve_sprinkler, bus.valve_drip, bus.pump_fill, bus.alarm, bus.grant_done}, 5'b0);
    bus.req_sprinkler = 1'b1; bus.req_drip = 1'b1;
    sv_cnt = 0; vd_cnt = 0; gd_cnt = 0;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 1) chk("t1_first_sprinkler", bus.state, 3'd1);
      if (i == 10) chk("t1_then_drip", bus.state, 3'd2);
      sv_cnt += int'(bus.valve_sprinkler);
      vd_cnt += int'(bus.valve_drip);
      gd_cnt += int'(bus.grant_done);
    end
    chk("t1_sprinkler_cycles", sv_cnt, 8);
    chk("t1_drip_cycles", vd_cnt, 8);
    chk("t1_grant_done_pulses", gd_cnt, 2);

    // Empty tank forces refill, full tank returns to IDLE then grants drip.
    do_reset();
    bus.water_tank_level = 4'b0000; bus.req_drip = 1'b1;
    step();
    chk("t2_refill", {bus.state, bus.pump_fill}, {3'd3, 1'b1});
    for (int i = 0; i < 9; i++) step();
    bus.water_tank_level = 4'b1111;
    step();
    chk("t2_back_idle", bus.state, 3'd0);
    step();
    chk("t2_drip", {bus.state, bus.valve_drip}, {3'd2, 1'b1});

    // Refill timeout into FAULT, then clear.
    do_reset();
    bus.water_tank_level = 4'b0000;
    step();
    bus.water_tank_level = 4'b0001;
    for (int i = 0; i < 31; i++) step();
    chk("t3_still_refill", bus.state, 3'd3);
    step();
    chk("t3_fault", {bus.state, bus.alarm, bus.pump_fill}, {3'd4, 1'b1, 1'b0});
    bus.clear_fault = 1'b1; bus.water_tank_level = 4'b1111;
    step();
    chk("t3_cleared", {bus.state, bus.alarm}, {3'd0, 1'b0});
    bus.clear_fault = 1'b0;

    // Level loss with simultaneous request drop mid-grant goes to REFILL.
    do_reset();
    bus.req_sprinkler = 1'b1;
    step(); step(); step();
    bus.water_tank_level = 4'b0000; bus.req_sprinkler = 1'b0;
    step();
    chk("t4_refill_not_idle", {bus.state, bus.valve_sprinkler, bus.grant_done}, {3'd3, 1'b0, 1'b0});

    // Non-thermometer level in IDLE.
    do_reset();
    bus.water_tank_level = 4'b0101; bus.req_sprinkler = 1'b1;
    step();
`ifdef SENSOR_CHECK_EN
    chk("t5_sensor_fault", {bus.state, bus.alarm}, {3'd4, 1'b1});
`else
    chk("t5_sprinkler_refused", {bus.state, bus.pump_fill}, {3'd3, 1'b1});
`endif

    // Reset in the middle of a refill.
    do_reset();
    bus.water_tank_level = 4'b0000;
    step();
    bus.water_tank_level = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    initialize = 1'b1;
    step();
    chk("t6_reset_midrefill", {bus.state, bus.valve_sprinkler, bus.valve_drip, bus.pump_fill, bus.alarm, bus.grant_done},
        {3'd0, 5'b0});
    initialize = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(4) == 0) bus.water_tank_level = 4'($urandom_range(15));
        else bus.water_tank_level = thermo_tab[$urandom_range(4)];
      end
      if ($urandom_range(5) == 0) bus.req_sprinkler = ~bus.req_sprinkler;
      if ($urandom_range(5) == 0) bus.req_drip = ~bus.req_drip;
      bus.clear_fault = ($urandom_range(3) == 0);
      initialize = ($urandom_range(499) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
